// File: rtl/hyper_titan_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hyper_titan_pkg
// Purpose  : Shared address map, AXI-Lite link types and SYS_CTRL definitions.
// Revision : 1.0 - initial release
// ============================================================================
package hyper_titan_pkg;

    localparam logic [31:0] SYS_CTRL_START    = 32'h4000_0000;
    localparam logic [31:0] SYS_CTRL_END      = 32'h4000_0FFF;
    localparam logic [31:0] RAM_START         = 32'h8000_0000;
    localparam logic [31:0] SYS_CTRL_ID_VALUE = 32'h4854_0001;

    // Byte offsets inside the 4 KiB SYS_CTRL window
    localparam logic [11:0] SYS_CTRL_ID_OFF      = 12'h000;
    localparam logic [11:0] SYS_CTRL_BOOT_OFF    = 12'h004;
    localparam logic [11:0] SYS_CTRL_CORE_OFF    = 12'h008;
    localparam logic [11:0] SYS_CTRL_STATUS_OFF  = 12'h00C;
    localparam logic [11:0] SYS_CTRL_SCRATCH_OFF = 12'h010;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        SYS_CTRL_IDLE    = 2'd0,
        SYS_CTRL_WR_RESP = 2'd1,
        SYS_CTRL_RD_RESP = 2'd2
    } sys_ctrl_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  prot;
    } axil_ax_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
    } axil_w_t;

    typedef struct packed {
        logic [1:0] resp;
    } axil_b_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } axil_r_t;

    typedef struct packed {
        axil_ax_t aw;
        logic     aw_valid;
        axil_w_t  w;
        logic     w_valid;
        logic     b_ready;
        axil_ax_t ar;
        logic     ar_valid;
        logic     r_ready;
    } pl_m_axil_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    w_ready;
        axil_b_t b;
        logic    b_valid;
        logic    ar_ready;
        axil_r_t r;
        logic    r_valid;
    } pl_m_axil_resp_t;

    function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] v;
        v = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) v[8*i +: 8] = new_val[8*i +: 8];
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sys_ctrl_axil.sv
`default_nettype none
// ============================================================================
// Module   : sys_ctrl_axil
// Purpose  : AXI-Lite system control registers (ID, boot address, core reset
//            release, status, scratch) with a single outstanding transaction.
// Revision : 1.0 - initial release
// ============================================================================
module sys_ctrl_axil
    import hyper_titan_pkg::*;
#(
    parameter logic [31:0] ID_VALUE      = SYS_CTRL_ID_VALUE,
    parameter logic [31:0] BOOT_ADDR_RST = RAM_START,
    parameter int          NUM_SCRATCH   = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  pl_m_axil_req_t  req_i,
    output pl_m_axil_resp_t resp_o,
    input  logic [31:0]     status_i,
    output logic [31:0]     boot_addr_o,
    output logic [1:0]      core_rst_rel_o
);

    sys_ctrl_state_e r_state;
    sys_ctrl_state_e w_state_nxt;

    logic [31:0] r_boot_addr;
    logic [1:0]  r_core_ctrl;
    logic [31:0] r_scratch [NUM_SCRATCH];
    logic [1:0]  r_b_resp;
    logic [31:0] r_r_data;
    logic [1:0]  r_r_resp;

    logic [9:0]  w_wr_word;
    logic [9:0]  w_rd_word;
    logic        w_idle;
    logic        w_wr_hs;
    logic        w_rd_hs;
    logic        w_wr_err;
    logic        w_wr_scr;
    logic        w_rd_err;
    logic [31:0] w_rd_data;
    logic        w_unused;

    assign w_wr_word = req_i.aw.addr[11:2];
    assign w_rd_word = req_i.ar.addr[11:2];
    assign w_idle    = (r_state == SYS_CTRL_IDLE);
    // AW and W are only ever taken as a pair; a complete write pair wins over AR
    assign w_wr_hs   = w_idle && req_i.aw_valid && req_i.w_valid;
    assign w_rd_hs   = w_idle && req_i.ar_valid && !(req_i.aw_valid && req_i.w_valid);
    assign w_wr_scr  = (w_wr_word[9:2] == SYS_CTRL_SCRATCH_OFF[11:4]) &&
                       (int'(w_wr_word[1:0]) < NUM_SCRATCH);

    assign w_unused = ^{req_i.aw.prot, req_i.ar.prot, req_i.aw.addr[31:12],
                        req_i.aw.addr[1:0], req_i.ar.addr[31:12], req_i.ar.addr[1:0]};

    always_comb begin
        w_wr_err = 1'b1;
        if (w_wr_word == SYS_CTRL_BOOT_OFF[11:2] || w_wr_word == SYS_CTRL_CORE_OFF[11:2] || w_wr_scr)
            w_wr_err = 1'b0;
    end

    always_comb begin
        w_rd_data = '0;
        w_rd_err  = 1'b0;
        case (w_rd_word)
            SYS_CTRL_ID_OFF[11:2]:     w_rd_data = ID_VALUE;
            SYS_CTRL_BOOT_OFF[11:2]:   w_rd_data = r_boot_addr;
            SYS_CTRL_CORE_OFF[11:2]:   w_rd_data = {30'd0, r_core_ctrl};
            SYS_CTRL_STATUS_OFF[11:2]: w_rd_data = status_i;
            default: begin
                if ((w_rd_word[9:2] == SYS_CTRL_SCRATCH_OFF[11:4]) &&
                    (int'(w_rd_word[1:0]) < NUM_SCRATCH)) begin
                    for (int k = 0; k < NUM_SCRATCH; k++) begin
                        if (w_rd_word[1:0] == 2'(k)) w_rd_data = r_scratch[k];
                    end
                end else begin
                    w_rd_err = 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SYS_CTRL_IDLE: begin
                if (w_wr_hs)      w_state_nxt = SYS_CTRL_WR_RESP;
                else if (w_rd_hs) w_state_nxt = SYS_CTRL_RD_RESP;
            end
            SYS_CTRL_WR_RESP: if (req_i.b_ready) w_state_nxt = SYS_CTRL_IDLE;
            SYS_CTRL_RD_RESP: if (req_i.r_ready) w_state_nxt = SYS_CTRL_IDLE;
            default:          w_state_nxt = SYS_CTRL_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= SYS_CTRL_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_boot_addr <= BOOT_ADDR_RST;
            r_core_ctrl <= 2'b00;
            for (int k = 0; k < NUM_SCRATCH; k++) r_scratch[k] <= '0;
        end else if (w_wr_hs) begin
            if (w_wr_word == SYS_CTRL_BOOT_OFF[11:2])
                r_boot_addr <= apply_strb(r_boot_addr, req_i.w.data, req_i.w.strb);
            if (w_wr_word == SYS_CTRL_CORE_OFF[11:2] && req_i.w.strb[0])
                r_core_ctrl <= req_i.w.data[1:0];
            for (int k = 0; k < NUM_SCRATCH; k++) begin
                if (w_wr_scr && w_wr_word[1:0] == 2'(k))
                    r_scratch[k] <= apply_strb(r_scratch[k], req_i.w.data, req_i.w.strb);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_b_resp <= AXI_RESP_OKAY;
            r_r_data <= '0;
            r_r_resp <= AXI_RESP_OKAY;
        end else begin
            if (w_wr_hs) r_b_resp <= w_wr_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            if (w_rd_hs) begin
                r_r_data <= w_rd_data;
                r_r_resp <= w_rd_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            end
        end
    end

    always_comb begin
        resp_o          = '0;
        resp_o.aw_ready = w_wr_hs;
        resp_o.w_ready  = w_wr_hs;
        resp_o.ar_ready = w_rd_hs;
        resp_o.b_valid  = (r_state == SYS_CTRL_WR_RESP);
        resp_o.b.resp   = r_b_resp;
        resp_o.r_valid  = (r_state == SYS_CTRL_RD_RESP);
        resp_o.r.data   = r_r_data;
        resp_o.r.resp   = r_r_resp;
    end

    assign boot_addr_o    = r_boot_addr;
    assign core_rst_rel_o = r_core_ctrl;

endmodule
`default_nettype wire

// File: tb/tb_sys_ctrl_axil.sv
`default_nettype none
// ============================================================================
// Module   : tb_sys_ctrl_axil
// Purpose  : Directed scoreboard bench for sys_ctrl_axil.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sys_ctrl_axil;
    import hyper_titan_pkg::*;

    logic            clk;
    logic            rst_n;
    pl_m_axil_req_t  req;
    pl_m_axil_resp_t resp;
    logic [31:0]     status;
    logic [31:0]     boot_addr;
    logic [1:0]      core_rel;

    int n_cmp = 0;
    int n_bad = 0;

    logic [1:0]  q_b[$];
    logic [33:0] q_r[$];

    sys_ctrl_axil dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .req_i          (req),
        .resp_o         (resp),
        .status_i       (status),
        .boot_addr_o    (boot_addr),
        .core_rst_rel_o (core_rel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: compare every B/R beat at its handshake against the scoreboard
    always @(negedge clk) begin
        if (resp.b_valid && req.b_ready) begin
            if (q_b.size() == 0) check("b_unexpected", 32'd1, 32'd0);
            else check("b_resp", {30'd0, resp.b.resp}, {30'd0, q_b.pop_front()});
        end
        if (resp.r_valid && req.r_ready) begin
            if (q_r.size() == 0) check("r_unexpected", 32'd1, 32'd0);
            else begin
                logic [33:0] e;
                e = q_r.pop_front();
                check("r_data", resp.r.data, e[33:2]);
                check("r_resp", {30'd0, resp.r.resp}, {30'd0, e[1:0]});
            end
        end
    end

    task automatic wait_wr_hs;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (resp.aw_ready && resp.w_ready) return;
        end
        check("aw_w_handshake_timeout", 32'd0, 32'd1);
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, input logic [1:0] er);
        q_b.push_back(er);
        @(posedge clk); #1;
        req.aw.addr = a; req.aw_valid = 1'b1;
        req.w.data = d; req.w.strb = s; req.w_valid = 1'b1;
        req.b_ready = 1'b1;
        wait_wr_hs();
        @(posedge clk); #1;
        req.aw_valid = 1'b0; req.w_valid = 1'b0;
        @(negedge clk);
        check("b_valid_latency", {31'd0, resp.b_valid}, 32'd1);
        @(posedge clk); #1;
        req.b_ready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] a, input logic [31:0] ed,
                            input logic [1:0] er, input int hold);
        int i;
        q_r.push_back({ed, er});
        @(posedge clk); #1;
        req.ar.addr = a; req.ar_valid = 1'b1;
        req.r_ready = (hold == 0);
        for (i = 0; i < 20; i++) begin
            @(negedge clk);
            if (resp.ar_ready) break;
        end
        if (i == 20) check("ar_handshake_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        req.ar_valid = 1'b0;
        @(negedge clk);
        check("r_valid_latency", {31'd0, resp.r_valid}, 32'd1);
        for (int k = 0; k < hold; k++) begin
            if (k > 0) @(negedge clk);
            check("r_hold_valid", {31'd0, resp.r_valid}, 32'd1);
            check("r_hold_data", resp.r.data, ed);
        end
        if (hold > 0) begin
            @(posedge clk); #1;
            req.r_ready = 1'b1;
            @(negedge clk);
        end
        @(posedge clk); #1;
        req.r_ready = 1'b0;
    endtask

    initial begin
        req    = '0;
        status = 32'hC0FF_EE42;
        rst_n  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_aw_ready", {31'd0, resp.aw_ready}, 32'd0);
        check("rst_b_valid", {31'd0, resp.b_valid}, 32'd0);
        check("rst_r_valid", {31'd0, resp.r_valid}, 32'd0);
        check("rst_r_data", resp.r.data, 32'd0);
        check("rst_boot_addr", boot_addr, 32'h8000_0000);
        check("rst_core_rel", {30'd0, core_rel}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Boot address write/read-back
        axi_write(32'h4000_0004, 32'h0001_0000, 4'hF, AXI_RESP_OKAY);
        check("boot_addr_after_wr", boot_addr, 32'h0001_0000);
        axi_read(32'h4000_0004, 32'h0001_0000, AXI_RESP_OKAY, 0);

        // Byte strobes and zero strobe on SCRATCH0
        axi_write(32'h4000_0010, 32'hAABB_CCDD, 4'b0101, AXI_RESP_OKAY);
        axi_read(32'h4000_0010, 32'h00BB_00DD, AXI_RESP_OKAY, 0);
        axi_write(32'h4000_0010, 32'hFFFF_FFFF, 4'b0000, AXI_RESP_OKAY);
        axi_read(32'h4000_0013, 32'h00BB_00DD, AXI_RESP_OKAY, 0);

        // RO/unmapped accesses, STATUS, CORE_CTRL upper bits
        axi_write(32'h4000_0000, 32'h1234_5678, 4'hF, AXI_RESP_SLVERR);
        axi_read(32'h4000_0000, 32'h4854_0001, AXI_RESP_OKAY, 0);
        axi_read(32'h4000_0040, 32'h0000_0000, AXI_RESP_SLVERR, 0);
        axi_write(32'h4000_0040, 32'h1234_5678, 4'hF, AXI_RESP_SLVERR);
        axi_read(32'h4000_000C, 32'hC0FF_EE42, AXI_RESP_OKAY, 0);

        // Simultaneous AW/W/AR: write first, AR only after B completes
        q_b.push_back(AXI_RESP_OKAY);
        q_r.push_back({32'h5A5A_1234, AXI_RESP_OKAY});
        @(posedge clk); #1;
        req.aw.addr = 32'h4000_0014; req.aw_valid = 1'b1;
        req.w.data = 32'h5A5A_1234; req.w.strb = 4'hF; req.w_valid = 1'b1;
        req.ar.addr = 32'h4000_0014; req.ar_valid = 1'b1;
        @(negedge clk);
        check("prio_aw_ready", {31'd0, resp.aw_ready}, 32'd1);
        check("prio_ar_ready", {31'd0, resp.ar_ready}, 32'd0);
        @(posedge clk); #1;
        req.aw_valid = 1'b0; req.w_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("prio_b_valid_held", {31'd0, resp.b_valid}, 32'd1);
            check("prio_ar_blocked", {31'd0, resp.ar_ready}, 32'd0);
        end
        @(posedge clk); #1;
        req.b_ready = 1'b1;
        @(negedge clk);
        check("prio_ar_in_b_hs", {31'd0, resp.ar_ready}, 32'd0);
        @(posedge clk); #1;
        req.b_ready = 1'b0;
        @(negedge clk);
        check("prio_ar_ready_idle", {31'd0, resp.ar_ready}, 32'd1);
        @(posedge clk); #1;
        req.ar_valid = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            check("prio_r_hold_valid", {31'd0, resp.r_valid}, 32'd1);
            check("prio_r_hold_data", resp.r.data, 32'h5A5A_1234);
        end
        @(posedge clk); #1;
        req.r_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        req.r_ready = 1'b0;

        // AW without W must not be accepted
        q_b.push_back(AXI_RESP_OKAY);
        @(posedge clk); #1;
        req.aw.addr = 32'h4000_0018; req.aw_valid = 1'b1; req.b_ready = 1'b1;
        req.w.data = 32'h0000_00A5; req.w.strb = 4'hF;
        repeat (4) begin
            @(negedge clk);
            check("aw_only_aw_ready", {31'd0, resp.aw_ready}, 32'd0);
            check("aw_only_w_ready", {31'd0, resp.w_ready}, 32'd0);
        end
        @(posedge clk); #1;
        req.w_valid = 1'b1;
        @(negedge clk);
        check("aw_w_pair_aw_ready", {31'd0, resp.aw_ready}, 32'd1);
        check("aw_w_pair_w_ready", {31'd0, resp.w_ready}, 32'd1);
        @(posedge clk); #1;
        req.aw_valid = 1'b0; req.w_valid = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        req.b_ready = 1'b0;
        axi_read(32'h4000_0018, 32'h0000_00A5, AXI_RESP_OKAY, 0);

        // Core release, then reset during a pending write response
        axi_write(32'h4000_0008, 32'hFFFF_FFFF, 4'hF, AXI_RESP_OKAY);
        check("core_rel_set", {30'd0, core_rel}, 32'd3);
        axi_read(32'h4000_0008, 32'h0000_0003, AXI_RESP_OKAY, 0);
        @(posedge clk); #1;
        req.aw.addr = 32'h4000_0010; req.aw_valid = 1'b1;
        req.w.data = 32'h1111_1111; req.w.strb = 4'hF; req.w_valid = 1'b1;
        wait_wr_hs();
        @(posedge clk); #1;
        req.aw_valid = 1'b0; req.w_valid = 1'b0;
        @(negedge clk);
        check("pending_b_valid", {31'd0, resp.b_valid}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_b_valid", {31'd0, resp.b_valid}, 32'd0);
        check("midrst_core_rel", {30'd0, core_rel}, 32'd0);
        check("midrst_boot_addr", boot_addr, 32'h8000_0000);
        @(posedge clk); #1;
        rst_n = 1'b1;
        req.b_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("postrst_no_b", {31'd0, resp.b_valid}, 32'd0);
        end
        @(posedge clk); #1;
        req.b_ready = 1'b0;
        axi_read(32'h4000_0010, 32'h0000_0000, AXI_RESP_OKAY, 0);

        repeat (3) @(posedge clk);
        check("scoreboard_b_drained", q_b.size(), 32'd0);
        check("scoreboard_r_drained", q_r.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
